// File: rtl/mem_data_seq_pkg.sv
// Shared constants and FSM encoding for the sequenced data memory.
package mem_data_seq_pkg;

  localparam int unsigned WORD_LEN_DEF  = 16;
  localparam int unsigned MEM_CELL_SIZE = 8;
  localparam int unsigned ADDR_LEN_DEF  = 16;
  localparam int unsigned DATA_MEM_SIZE = 256;
  localparam int unsigned LATENCY_DEF   = 1;
  localparam int unsigned CELLS_DEF     = WORD_LEN_DEF / MEM_CELL_SIZE;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Number of memory cells that make up one data word.
  function automatic int unsigned cells_of(input int unsigned word_len,
                                           input int unsigned cell_len);
    return word_len / cell_len;
  endfunction

endpackage

// File: rtl/mem_data_seq_ctrl.sv
// Sequencer for mem_data_seq: clear sweep, request acceptance, latency count.
module mem_data_seq_ctrl
  import mem_data_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = DATA_MEM_SIZE,
  parameter int unsigned CELLS   = CELLS_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output state_t        state,
  output logic [AW-1:0] clr_ptr,
  output logic          req_ready,
  output logic          busy,
  output logic          accept_c
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] lat_cnt;

  assign accept_c = req_valid & req_ready;

  // State, clear pointer, latency counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      lat_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(CELLS);
          if (clr_ptr == AW'(DEPTH - CELLS)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_c) begin
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= ST_ACCESS;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= CW'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - CW'(1);
          if (lat_cnt == CW'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_CLEAR;
          clr_ptr   <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_data_seq.sv
// Handshaked, big-endian, cell-addressed data memory with latency and clear.
// Optional macro MEM_DATA_SEQ_ALIGN_CHECK_EN flags misaligned/out-of-range
// requests with resp_err and suppresses their writes.
module mem_data_seq
  import mem_data_seq_pkg::*;
#(
  parameter int unsigned WORD_LEN = WORD_LEN_DEF,
  parameter int unsigned CELL_LEN = MEM_CELL_SIZE,
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DEPTH    = DATA_MEM_SIZE,
  parameter int unsigned LATENCY  = LATENCY_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_LEN-1:0]          req_addr,
  input  logic [WORD_LEN-1:0]          req_wdata,
  input  logic [WORD_LEN/CELL_LEN-1:0] req_cellEn,
  output logic                         resp_valid,
  output logic [WORD_LEN-1:0]          resp_rdata,
  output logic                         resp_err,
  output logic                         busy
);

  localparam int unsigned CELLS = cells_of(WORD_LEN, CELL_LEN);
  localparam int unsigned AW    = $clog2(DEPTH);

  state_t               state;
  logic [AW-1:0]        clr_ptr;
  logic                 accept_c;
  logic                 access_c;

  logic                 cap_write;
  logic [ADDR_LEN-1:0]  cap_addr;
  logic [WORD_LEN-1:0]  cap_wdata;
  logic [CELLS-1:0]     cap_en;

  logic [CELL_LEN-1:0]  mem [DEPTH];
  logic [AW-1:0]        lane_idx [CELLS];
  logic [CELLS-1:0]     lane_we_c;
  logic [WORD_LEN-1:0]  new_word_c;
  logic                 err_c;

  mem_data_seq_ctrl #(
    .DEPTH  (DEPTH),
    .CELLS  (CELLS),
    .LATENCY(LATENCY),
    .AW     (AW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .state    (state),
    .clr_ptr  (clr_ptr),
    .req_ready(req_ready),
    .busy     (busy),
    .accept_c (accept_c)
  );

  assign access_c = (state == ST_ACCESS);

`ifdef MEM_DATA_SEQ_ALIGN_CHECK_EN
  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ADDR_LEN'(CELLS - 1);
  assign err_c = ((cap_addr & ALIGN_MASK) != '0) ||
                 ({1'b0, cap_addr} >= (ADDR_LEN + 1)'(DEPTH));
`else
  logic addr_bits_unused;
  assign err_c            = 1'b0;
  assign addr_bits_unused = ^cap_addr;
`endif

  // Lane k (0 = most significant cell) maps to (addr mod DEPTH + k) mod DEPTH.
  for (genvar k = 0; k < CELLS; k++) begin : g_lane
    assign lane_idx[k]  = cap_addr[AW-1:0] + AW'(k);
    assign lane_we_c[k] = cap_write & cap_en[CELLS-1-k] & ~err_c;
    assign new_word_c[(CELLS-1-k)*CELL_LEN +: CELL_LEN] =
      lane_we_c[k] ? cap_wdata[(CELLS-1-k)*CELL_LEN +: CELL_LEN] : mem[lane_idx[k]];
  end

  // Request capture on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_en    <= '0;
    end else if (accept_c) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_en    <= req_cellEn;
    end
  end

  // Cell array: clear sweep or enabled-lane write on the access edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        for (int unsigned k = 0; k < CELLS; k++) begin
          mem[clr_ptr + AW'(k)] <= '0;
        end
      end else if (access_c) begin
        for (int unsigned k = 0; k < CELLS; k++) begin
          if (lane_we_c[k]) mem[lane_idx[k]] <= cap_wdata[(CELLS-1-k)*CELL_LEN +: CELL_LEN];
        end
      end
    end
  end

  // Response pulse with post-write word, held until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= access_c;
      if (access_c) begin
        resp_rdata <= err_c ? '0 : new_word_c;
        resp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_seq.sv
// Scoreboard bench for mem_data_seq (LATENCY=3, 16-bit words of two 8-bit cells).
module tb_mem_data_seq;

  localparam int LAT = 3;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_cellEn;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_resp = 0;
  exp_t exp_q[$];

  logic [15:0] b_addr [8];
  logic [15:0] b_exp  [8];

  mem_data_seq #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_cellEn(req_cellEn),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation, including its arrival cycle.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h required no response", resp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        n_resp++;
      end
    end
  end

  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] en, input logic [15:0] er, input logic ee);
    int g;
    g = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_cellEn = en;
    while (req_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=%b required 1 within 100 cycles", req_ready);
      req_valid = 1'b0;
    end else begin
      exp_q.push_back('{rdata: er, err: ee, cyc: cyc + 1 + LAT});
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Called on the first negedge with rst low; counts cycles with busy high.
  task automatic count_clear();
    int n;
    int rdy_bad;
    n = 0;
    rdy_bad = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (req_ready !== 1'b0) rdy_bad++;
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", 32'(n), 32'd128);
    chk("clear_ready_low", 32'(rdy_bad), 32'd0);
    chk("post_clear_ready", 32'(req_ready), 32'd1);
    chk("post_clear_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish within 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int resp_before;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_cellEn = '0;
    b_addr = '{16'h0010, 16'h0020, 16'h0011, 16'h000F, 16'h0030, 16'h0010, 16'h0020, 16'h001F};
    b_exp  = '{16'hBEEF, 16'h1234, 16'hEF00, 16'h00BE, 16'h0000, 16'hBEEF, 16'h1234, 16'h0012};

    // Reset state and initial clear
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    count_clear();

    // Every cell reads back as zero
    for (int a = 0; a < 256; a += 2) do_req(1'b0, 16'(a), 16'h0, 2'b00, 16'h0000, 1'b0);

    // Big-endian word write and cell placement
    do_req(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0);
    do_req(1'b0, 16'h0010, 16'h0, 2'b00, 16'hBEEF, 1'b0);
    do_req(1'b0, 16'h0011, 16'h0, 2'b00, 16'hEF00, 1'b0);
    do_req(1'b0, 16'h000F, 16'h0, 2'b00, 16'h00BE, 1'b0);

    // Per-cell write enables
    do_req(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h1234, 1'b0);
    do_req(1'b1, 16'h0020, 16'hABCD, 2'b01, 16'h12CD, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0, 2'b00, 16'h12CD, 1'b0);
    do_req(1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h12CD, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0, 2'b00, 16'h12CD, 1'b0);

    // Top-of-memory wrap and out-of-range address
`ifdef MEM_DATA_SEQ_ALIGN_CHECK_EN
    do_req(1'b1, 16'h00FF, 16'hA55A, 2'b11, 16'h0000, 1'b1);
    do_req(1'b0, 16'h00FF, 16'h0, 2'b00, 16'h0000, 1'b1);
    do_req(1'b0, 16'h00FE, 16'h0, 2'b00, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0000, 16'h0, 2'b00, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0110, 16'h0, 2'b00, 16'h0000, 1'b1);
`else
    do_req(1'b1, 16'h00FF, 16'hA55A, 2'b11, 16'hA55A, 1'b0);
    do_req(1'b0, 16'h00FF, 16'h0, 2'b00, 16'hA55A, 1'b0);
    do_req(1'b0, 16'h00FE, 16'h0, 2'b00, 16'h00A5, 1'b0);
    do_req(1'b0, 16'h0000, 16'h0, 2'b00, 16'h5A00, 1'b0);
    do_req(1'b0, 16'h0110, 16'h0, 2'b00, 16'hBEEF, 1'b0);
`endif
    wait_drain();

    // Reset two cycles into a write: no response, clear reruns
    resp_before = n_resp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5555; req_cellEn = 2'b11;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_clear();
    chk("mid_rst_no_resp", 32'(n_resp - resp_before), 32'd0);
    do_req(1'b0, 16'h0040, 16'h0, 2'b00, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0010, 16'h0, 2'b00, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0, 2'b00, 16'h0000, 1'b0);

    // Back-to-back reads with req_valid held high
    do_req(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0);
    do_req(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h1234, 1'b0);
    wait_drain();
    resp_before = n_resp;
    begin
      int i;
      int g;
      i = 0;
      g = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = b_addr[0]; req_cellEn = 2'b00;
      while (i < 8 && g < 200) begin
        if (req_ready === 1'b1) begin
          exp_q.push_back('{rdata: b_exp[i], err: 1'b0, cyc: cyc + 1 + LAT});
          @(posedge clk);
          #1;
          i++;
          if (i < 8) req_addr = b_addr[i];
          else req_valid = 1'b0;
        end
        @(negedge clk);
        g++;
      end
      req_valid = 1'b0;
      chk("b2b_accepted", 32'(i), 32'd8);
    end
    wait_drain();
    chk("b2b_responses", 32'(n_resp - resp_before), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
